cdc_req_sched: RTL and testbench

//   Schedules N_REQ event requesters onto one shared slow-to-fast level-synchronizer

---
 rtl/cdc_req_sched.sv | 128 ++++++++++++
 tb/tb_cdc_req_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cdc_req_sched.sv
// Round-robin scheduler that time-shares one slow-to-fast level synchronizer among N_REQ requesters.
// Optional feature: define CDC_DROP_CNT_EN to add the saturating drop_cnt output.
module cdc_req_sched #(
  parameter int N_REQ    = 4,
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 2,
  parameter int ID_W     = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  output logic             sig_out,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic [N_REQ-1:0] done,
`ifdef CDC_DROP_CNT_EN
  output logic [7:0]       drop_cnt,
`endif
  output logic [1:0]       fsm_state
);

  localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d, done_d, clr;
  logic [ID_W-1:0]  last_q, last_d, grant_d, sel;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_vld, sig_d, take;

  assign fsm_state = state_q;

  // First pending requester at or after last+1, wrapping modulo N_REQ.
  always_comb begin : pick
    int idx;
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!sel_vld && pend_q[idx]) begin
        sel     = idx[ID_W-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_out;
    grant_d = grant_id;
    last_d  = last_q;
    done_d  = '0;
    clr     = '0;
    take    = 1'b0;
    case (state_q)
      IDLE: take = sel_vld;
      HOLD: begin
        if (cnt_q == '0) begin
          sig_d            = 1'b0;
          done_d[grant_id] = 1'b1;
          cnt_d            = GAP_LD;
          state_d          = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          take    = sel_vld;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A grant straight out of GAP avoids an idle bubble between events.
    if (take) begin
      grant_d    = sel;
      last_d     = sel;
      clr[sel]   = 1'b1;
      sig_d      = 1'b1;
      cnt_d      = HOLD_LD;
      state_d    = HOLD;
    end
    // Set wins: a request arriving on its own grant edge stays pending.
    pend_d = (pend_q & ~clr) | req;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      last_q   <= ID_W'(N_REQ - 1);
      sig_out  <= 1'b0;
      grant_id <= '0;
      busy     <= 1'b0;
      done     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      last_q   <= last_d;
      sig_out  <= sig_d;
      grant_id <= grant_d;
      busy     <= (state_d != IDLE);
      done     <= done_d;
    end
  end

`ifdef CDC_DROP_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt <= '0;
    end else if ((|(req & pend_q)) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdc_req_sched.sv
// Directed bench for cdc_req_sched: grant timing, round robin, coalescing, async reset,
// and a 4x fast-domain synchronizer model counting events.
module tb_cdc_req_sched;

  logic       clk = 1'b0;
  logic       fclk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] req = '0;
  logic       sig_out;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] done;
  logic [1:0] fsm_state;
`ifdef CDC_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] inj [0:31];
  int         exp_g [0:7];

  // clock / reset
  always #20 clk = ~clk;
  initial begin
    #2;
    forever #5 fclk = ~fclk;
  end

  cdc_req_sched #(.N_REQ(4), .HOLD_CYC(2), .GAP_CYC(2), .ID_W(2)) dut (
    .clk(clk),
    .rstn(rstn),
    .req(req),
    .sig_out(sig_out),
    .grant_id(grant_id),
    .busy(busy),
    .done(done),
`ifdef CDC_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .fsm_state(fsm_state)
  );

  // fast-domain two-flop synchronizer plus rising-edge counter
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   sync_cnt = 0;
  int   done_cnt = 0;
  always @(posedge fclk) begin
    s1 <= sig_out;
    s2 <= s1;
    s3 <= s2;
    if (s2 && !s3) sync_cnt <= sync_cnt + 1;
  end
  always @(negedge clk) done_cnt <= done_cnt + $countones(done);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input string tag);
    rstn = 1'b0;
    req  = '0;
    tick();
    tick();
    check({tag, "_rst_sig"}, sig_out, 0);
    check({tag, "_rst_gid"}, grant_id, 0);
    check({tag, "_rst_busy"}, busy, 0);
    check({tag, "_rst_done"}, done, 0);
    check({tag, "_rst_state"}, fsm_state, 0);
`ifdef CDC_DROP_CNT_EN
    check({tag, "_rst_drop"}, drop_cnt, 0);
`endif
    rstn = 1'b1;
    tick();
  endtask

  // Drives inj[c] into edge c; from edge 1 on expects back-to-back grants exp_g[0..n-1].
  task automatic run_seq(input string tag, input int n_grants);
    int g, p, run, max_run;
    run = 0;
    max_run = 0;
    for (int c = 0; c <= 4 * n_grants; c++) begin
      req = inj[c];
      tick();
      req = '0;
      if (c >= 1) begin
        g = (c - 1) / 4;
        p = (c - 1) % 4;
        run = sig_out ? run + 1 : 0;
        if (run > max_run) max_run = run;
        check($sformatf("%s_c%0d_sig", tag, c), sig_out, (p < 2) ? 1 : 0);
        check($sformatf("%s_c%0d_gid", tag, c), grant_id, exp_g[g]);
        check($sformatf("%s_c%0d_done", tag, c), done, (p == 2) ? (32'd1 << exp_g[g]) : 0);
        check($sformatf("%s_c%0d_busy", tag, c), busy, 1);
        check($sformatf("%s_c%0d_state", tag, c), fsm_state, (p < 2) ? 1 : 2);
      end
    end
    tick();
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_sig"}, sig_out, 0);
    check({tag, "_end_state"}, fsm_state, 0);
    check({tag, "_max_high"}, max_run, 2);
    for (int i = 0; i < 32; i++) inj[i] = '0;
  endtask

  initial begin
    int sync0, done0;
    for (int i = 0; i < 32; i++) inj[i] = '0;

    // Test 1: single request from requester 0
    reset_dut("t1");
    inj[0] = 4'b0001;
    exp_g[0] = 0;
    run_seq("t1", 1);

    // Test 2: all four at once, served 0,1,2,3
    reset_dut("t2");
    inj[0] = 4'b1111;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3;
    run_seq("t2", 4);

    // Test 3: req[2] on requester 2's own grant edge is kept and served after 3
    reset_dut("t3");
    inj[0] = 4'b1111;
    inj[9] = 4'b0100;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 2;
    run_seq("t3", 5);
`ifdef CDC_DROP_CNT_EN
    check("t3_drop", drop_cnt, 1);
`endif

    // Test 4: three req[1] pulses around one hold coalesce into one grant
    reset_dut("t4");
    inj[0] = 4'b0001;
    inj[1] = 4'b0010; inj[2] = 4'b0010; inj[3] = 4'b0010;
    exp_g[0] = 0; exp_g[1] = 1;
    run_seq("t4", 2);
`ifdef CDC_DROP_CNT_EN
    check("t4_drop", drop_cnt, 2);
`endif

    // Test 5: async reset in the middle of HOLD
    reset_dut("t5");
    req = 4'b0011;
    tick();
    req = '0;
    tick();
    check("t5_pre_sig", sig_out, 1);
    check("t5_pre_busy", busy, 1);
    #5;
    rstn = 1'b0;
    #1;
    check("t5_async_sig", sig_out, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_state", fsm_state, 0);
    check("t5_async_gid", grant_id, 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t5_idle%0d_busy", i), busy, 0);
      check($sformatf("t5_idle%0d_sig", i), sig_out, 0);
    end
    inj[0] = 4'b0001;
    exp_g[0] = 0;
    run_seq("t5", 1);

    // Test 6: fast-domain synchronizer sees one pulse per grant
    reset_dut("t6");
    sync0 = sync_cnt;
    done0 = done_cnt;
    inj[0] = 4'b1111;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3;
    run_seq("t6", 4);
    tick();
    tick();
    check("t6_sync_pulses", sync_cnt - sync0, 4);
    check("t6_done_pulses", done_cnt - done0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
